// File: rtl/rvfi_check_sequencer.sv
// Watches one RVFI retire channel, skips the first SKIP retirements, freezes the
// next retired packet into chk_* and pulses 'check'. Flags a stall on retire timeout or early halt.
module rvfi_check_sequencer #(
    parameter int NRET    = 1,
    parameter int ILEN    = 32,
    parameter int XLEN    = 32,
    parameter int CHANNEL = 0,
    parameter int SKIP    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   arm,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [NRET*ILEN-1:0]   rvfi_insn,
    input  logic [NRET-1:0]        rvfi_trap,
    input  logic [NRET-1:0]        rvfi_halt,
    input  logic [NRET*5-1:0]      rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
    input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
    output logic                   check,
    output logic [ILEN-1:0]        chk_insn,
    output logic                   chk_trap,
    output logic [4:0]             chk_rd_addr,
    output logic [XLEN-1:0]        chk_rd_wdata,
    output logic [XLEN/8-1:0]      chk_mem_wmask,
    output logic                   busy,
    output logic                   done,
    output logic                   stall,
    output logic [15:0]            retire_cnt
);

    localparam int          TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0] SKIP_CNT   = 16'(SKIP);
    localparam logic [15:0] CNT_AFTER  = (SKIP >= 65535) ? 16'hFFFF : 16'(SKIP + 1);

    typedef enum logic [2:0] {IDLE, COUNT, FIRE, DONE, STALL} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          rv, halt;
    logic          capture, count_inc, timer_inc, timer_clr, cnt_clr;

    assign rv   = rvfi_valid[CHANNEL];
    assign halt = rvfi_halt[CHANNEL];

    // Other channels are deliberately ignored; fold them so they do not look forgotten.
    logic unused_channels;
    assign unused_channels = ^{rvfi_valid, rvfi_insn, rvfi_trap, rvfi_halt,
                               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_wmask};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        count_inc  = 1'b0;
        timer_inc  = 1'b0;
        timer_clr  = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: if (arm) begin
                state_next = COUNT;
                cnt_clr    = 1'b1;
                timer_clr  = 1'b1;
            end
            COUNT: begin
                if (rv) begin
                    if (retire_cnt == SKIP_CNT) begin
                        capture    = 1'b1;
                        state_next = FIRE;
                    end else if (halt) begin
                        state_next = STALL;
                    end else begin
                        count_inc = 1'b1;
                        timer_clr = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_next = STALL;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            FIRE:    state_next = DONE;
            DONE:    state_next = DONE;
            STALL:   state_next = STALL;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are flops loaded from the next state, so they line up with 'state'.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            check         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            stall         <= 1'b0;
            retire_cnt    <= '0;
            timer         <= '0;
            chk_insn      <= '0;
            chk_trap      <= 1'b0;
            chk_rd_addr   <= '0;
            chk_rd_wdata  <= '0;
            chk_mem_wmask <= '0;
        end else begin
            check <= (state_next == FIRE);
            busy  <= (state_next == COUNT) || (state_next == FIRE);
            done  <= (state_next == DONE);
            stall <= (state_next == STALL);

            if (cnt_clr)
                retire_cnt <= '0;
            else if (count_inc && retire_cnt != 16'hFFFF)
                retire_cnt <= retire_cnt + 16'd1;
            else if (state == FIRE)
                retire_cnt <= CNT_AFTER;

            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;

            if (capture) begin
                chk_insn      <= rvfi_insn[CHANNEL*ILEN +: ILEN];
                chk_trap      <= rvfi_trap[CHANNEL];
                chk_rd_addr   <= rvfi_rd_addr[CHANNEL*5 +: 5];
                chk_rd_wdata  <= rvfi_rd_wdata[CHANNEL*XLEN +: XLEN];
                chk_mem_wmask <= rvfi_mem_wmask[CHANNEL*(XLEN/8) +: XLEN/8];
            end
        end
    end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: three configurations on a shared clock, captured
// packets scored against a queue of expected packets filled as stimulus is driven.
module tb_rvfi_check_sequencer;

    typedef struct packed {
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } pkt_t;

    int   checks = 0;
    int   errors = 0;
    int   fires_a = 0, fires_b = 0, fires_d = 0;
    pkt_t exp_q[$];

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic arm_a = 1'b0, arm_b = 1'b0, arm_d = 1'b0;

    // single-channel bus shared by dut_a and dut_b
    logic [0:0]  valid = '0, trap = '0, halt = '0;
    logic [31:0] insn = '0, wdata = '0;
    logic [4:0]  rd = '0;
    logic [3:0]  wmask = '0;

    // two-channel bus for dut_d
    logic [1:0]  d_valid = '0, d_trap = '0, d_halt = '0;
    logic [63:0] d_insn = '0, d_wdata = '0;
    logic [9:0]  d_rd = '0;
    logic [7:0]  d_wmask = '0;

    logic        chk_a, trap_a, busy_a, done_a, stall_a;
    logic [31:0] ins_a, wd_a;
    logic [4:0]  rd_a;
    logic [3:0]  wm_a;
    logic [15:0] cnt_a;
    logic        chk_b, trap_b, busy_b, done_b, stall_b;
    logic [31:0] ins_b, wd_b;
    logic [4:0]  rd_b;
    logic [3:0]  wm_b;
    logic [15:0] cnt_b;
    logic        chk_d, trap_d, busy_d, done_d, stall_d;
    logic [31:0] ins_d, wd_d;
    logic [4:0]  rd_d;
    logic [3:0]  wm_d;
    logic [15:0] cnt_d;

    rvfi_check_sequencer #(.NRET(1), .CHANNEL(0), .SKIP(4), .TIMEOUT(64)) dut_a (
        .clock(clock), .resetn(resetn), .arm(arm_a),
        .rvfi_valid(valid), .rvfi_insn(insn), .rvfi_trap(trap), .rvfi_halt(halt),
        .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata), .rvfi_mem_wmask(wmask),
        .check(chk_a), .chk_insn(ins_a), .chk_trap(trap_a), .chk_rd_addr(rd_a),
        .chk_rd_wdata(wd_a), .chk_mem_wmask(wm_a),
        .busy(busy_a), .done(done_a), .stall(stall_a), .retire_cnt(cnt_a));

    rvfi_check_sequencer #(.NRET(1), .CHANNEL(0), .SKIP(0), .TIMEOUT(8)) dut_b (
        .clock(clock), .resetn(resetn), .arm(arm_b),
        .rvfi_valid(valid), .rvfi_insn(insn), .rvfi_trap(trap), .rvfi_halt(halt),
        .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata), .rvfi_mem_wmask(wmask),
        .check(chk_b), .chk_insn(ins_b), .chk_trap(trap_b), .chk_rd_addr(rd_b),
        .chk_rd_wdata(wd_b), .chk_mem_wmask(wm_b),
        .busy(busy_b), .done(done_b), .stall(stall_b), .retire_cnt(cnt_b));

    rvfi_check_sequencer #(.NRET(2), .CHANNEL(1), .SKIP(1), .TIMEOUT(8)) dut_d (
        .clock(clock), .resetn(resetn), .arm(arm_d),
        .rvfi_valid(d_valid), .rvfi_insn(d_insn), .rvfi_trap(d_trap), .rvfi_halt(d_halt),
        .rvfi_rd_addr(d_rd), .rvfi_rd_wdata(d_wdata), .rvfi_mem_wmask(d_wmask),
        .check(chk_d), .chk_insn(ins_d), .chk_trap(trap_d), .chk_rd_addr(rd_d),
        .chk_rd_wdata(wd_d), .chk_mem_wmask(wm_d),
        .busy(busy_d), .done(done_d), .stall(stall_d), .retire_cnt(cnt_d));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic pkt_t mk_pkt(input logic [31:0] i, input logic t);
        return '{insn: i, trap: t, rd: i[4:0], wdata: 32'hC0DE_0000 ^ i, wmask: i[3:0]};
    endfunction

    task automatic score(input string tag, input pkt_t got);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, exp_q.size(), 1);
        else                   check(tag, got, exp_q.pop_front());
    endtask

    always @(negedge clock) if (chk_a) begin fires_a++; score("pkt_a", {ins_a, trap_a, rd_a, wd_a, wm_a}); end
    always @(negedge clock) if (chk_b) begin fires_b++; score("pkt_b", {ins_b, trap_b, rd_b, wd_b, wm_b}); end
    always @(negedge clock) if (chk_d) begin fires_d++; score("pkt_d", {ins_d, trap_d, rd_d, wd_d, wm_d}); end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        valid = '0; trap = '0; halt = '0;
        d_valid = '0; d_trap = '0; d_halt = '0;
    endtask

    task automatic retire(input logic [31:0] i, input logic t, input logic h);
        pkt_t p;
        p = mk_pkt(i, t);
        valid = 1'b1; halt = h;
        {insn, trap, rd, wdata, wmask} = p;
    endtask

    // channel 1 carries the observed retire; channel 0 always retires with trap set
    task automatic retire_d(input logic [31:0] i1, input logic v1, input logic [31:0] i0, input logic h0);
        pkt_t p1, p0;
        p1 = mk_pkt(i1, 1'b0);
        p0 = mk_pkt(i0, 1'b1);
        d_valid = {v1, 1'b1};
        d_halt  = {1'b0, h0};
        d_insn  = {p1.insn, p0.insn};
        d_trap  = {p1.trap, p0.trap};
        d_rd    = {p1.rd, p0.rd};
        d_wdata = {p1.wdata, p0.wdata};
        d_wmask = {p1.wmask, p0.wmask};
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        arm_a = 1'b0; arm_b = 1'b0; arm_d = 1'b0;
        idle();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [127:0] outs_a();
        return {chk_a, ins_a, trap_a, rd_a, wd_a, wm_a, busy_a, done_a, stall_a, cnt_a};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_a", outs_a(), 0);
        check("rst_b", {chk_b, busy_b, done_b, stall_b, cnt_b, ins_b}, 0);

        // 1: SKIP=4, five retires, the fifth is captured
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        check("t1_busy", busy_a, 1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            retire(i, 1'b0, 1'b0);
            if (i == 5) exp_q.push_back(mk_pkt(5, 1'b0));
            tick();
            if (i < 5) check("t1_no_check", chk_a, 0);
        end
        idle();
        check("t1_check", chk_a, 1);
        check("t1_cnt_fire", cnt_a, 4);
        tick();
        check("t1_check_off", chk_a, 0);
        check("t1_done", {done_a, busy_a, stall_a}, 3'b100);
        check("t1_cnt", cnt_a, 5);
        // arm and retires ignored once done
        arm_a = 1'b1; retire(9, 1'b0, 1'b0); tick(); tick(); arm_a = 1'b0; idle();
        check("t1_hold", {done_a, ins_a}, {1'b1, 32'd5});
        check("t1_fires", fires_a, 1);

        // 2: SKIP=0, retire in arm cycle ignored, next retire captured
        arm_b = 1'b1; retire(99, 1'b0, 1'b0); tick(); arm_b = 1'b0;
        retire(0, 1'b1, 1'b0); exp_q.push_back(mk_pkt(0, 1'b1)); tick(); idle();
        check("t2_check", {chk_b, busy_b}, 2'b11);
        tick();
        check("t2_after", {chk_b, busy_b, done_b}, 3'b001);
        check("t2_cnt", cnt_b, 1);
        check("t2_fires", fires_b, 1);

        // 3: TIMEOUT=8, no retires -> stall on the 8th cycle after entering COUNT
        do_reset();
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        repeat (7) tick();
        check("t3_pre", {stall_b, busy_b}, 2'b01);
        tick();
        check("t3_stall", {stall_b, busy_b, done_b, chk_b}, 4'b1000);
        repeat (3) tick();
        check("t3_fires", fires_b, 1);

        // 4: SKIP=4, halt on 2nd retire -> stall with retire_cnt=1
        do_reset();
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        retire(1, 1'b0, 1'b0); tick(); idle(); tick();
        retire(2, 1'b0, 1'b1); tick(); idle();
        check("t4_stall", {stall_a, done_a, busy_a}, 3'b100);
        check("t4_cnt", cnt_a, 1);
        check("t4_chk_zero", {ins_a, trap_a, rd_a, wd_a, wm_a}, 0);

        // 5: reset asserted during the capture cycle, then a clean re-run
        do_reset();
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin retire(i, 1'b0, 1'b0); tick(); end
        retire(5, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check("t5_async", outs_a(), 0);
        tick();
        resetn = 1'b1; idle();
        tick();
        check("t5_aborted", outs_a(), 0);
        check("t5_fires", fires_a, 1);
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        for (int i = 11; i <= 15; i++) begin
            retire(i, 1'b0, 1'b0);
            if (i == 15) exp_q.push_back(mk_pkt(15, 1'b0));
            tick();
        end
        idle();
        check("t5_check", chk_a, 1);
        tick();
        check("t5_done", {done_a, cnt_a, ins_a}, {1'b1, 16'd5, 32'd15});

        // 6: NRET=2 CHANNEL=1, channel 0 traffic only -> timeout with retire_cnt=0
        do_reset();
        arm_d = 1'b1; tick(); arm_d = 1'b0;
        for (int i = 0; i < 7; i++) begin retire_d(0, 1'b0, 40 + i, 1'b0); tick(); end
        check("t6_pre", {stall_d, busy_d, cnt_d}, {2'b01, 16'd0});
        retire_d(0, 1'b0, 50, 1'b1); tick();
        check("t6_stall", {stall_d, busy_d, cnt_d}, {2'b10, 16'd0});
        // channel 1 retires restart the timer and lead to a capture
        do_reset();
        arm_d = 1'b1; tick(); arm_d = 1'b0;
        retire_d(21, 1'b1, 60, 1'b1); tick();
        check("t6_cnt1", {cnt_d, stall_d}, {16'd1, 1'b0});
        for (int i = 0; i < 7; i++) begin retire_d(0, 1'b0, 70 + i, 1'b0); tick(); end
        check("t6_timer_reset", {stall_d, busy_d}, 2'b01);
        retire_d(22, 1'b1, 80, 1'b0); exp_q.push_back(mk_pkt(22, 1'b0)); tick(); idle();
        check("t6_check", chk_d, 1);
        tick();
        check("t6_done", {done_d, cnt_d, chk_d}, {1'b1, 16'd2, 1'b0});

        tick();
        check("q_drained", exp_q.size(), 0);
        check("fires_total", {fires_a[7:0], fires_b[7:0], fires_d[7:0]}, {8'd2, 8'd1, 8'd1});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
